branch_repair_ctrl: RTL

Front-end repair controller that consumes the branch-mispredict flush request produced at PREMEM (second branch amend) and turns it into a registered fetch redirect, a global-history/RAS checkpoint restore, and sequential BTB and PHT training writes. Sits between the PREMEM stage and the fetch/prediction units. It is the receiving end of the `flush / erroVAddr / corrDest / corrTake / checkPoint / repairAction` interface.

---
 rtl/branch_repair_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/branch_repair_ctrl.sv
// Mispredict repair controller: latches a PREMEM flush request, issues a one-cycle
// fetch redirect plus checkpoint restore, then BTB and PHT training writes. Optional: BRU_PERF_CNT_EN.
module branch_repair_ctrl #(
    parameter int CKPT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sba_flush_i,
    input  logic [31:0]       sba_erroVAddr_i,
    input  logic [31:0]       sba_corrDest_i,
    input  logic              sba_corrTake_i,
    input  logic [CKPT_W-1:0] sba_checkPoint_i,
    input  logic [3:0]        sba_repairAction_i,
    input  logic              cp0_excOccur_i,
    output logic              redirect_valid_o,
    output logic [31:0]       redirect_pc_o,
    output logic              ckpt_restore_o,
    output logic              ras_restore_o,
    output logic [CKPT_W-1:0] ckpt_o,
    output logic              btb_upd_valid_o,
    input  logic              btb_upd_ready_i,
    output logic [31:0]       btb_upd_pc_o,
    output logic [31:0]       btb_upd_target_o,
    output logic              pht_upd_valid_o,
    input  logic              pht_upd_ready_i,
    output logic [31:0]       pht_upd_pc_o,
    output logic              pht_upd_take_o,
    output logic              busy_o,
    output logic [31:0]       perf_repair_cnt_o
);

    typedef enum logic [1:0] {IDLE, REDIR, BTB_WR, PHT_WR} state_t;

    state_t            state, state_nxt;
    logic [31:0]       vaddr_q, dest_q, rpc_q;
    logic              take_q;
    logic [CKPT_W-1:0] ckpt_q;
    logic [3:1]        act_q;
    logic              accept;

    assign accept = sba_flush_i && sba_repairAction_i[0] && !cp0_excOccur_i;

    // A new accept always wins: the previous request's fields are simply overwritten.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            vaddr_q <= '0;
            dest_q  <= '0;
            rpc_q   <= '0;
            take_q  <= 1'b0;
            ckpt_q  <= '0;
            act_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                vaddr_q <= sba_erroVAddr_i;
                dest_q  <= sba_corrDest_i;
                rpc_q   <= sba_corrTake_i ? sba_corrDest_i : sba_erroVAddr_i + 32'd8;
                take_q  <= sba_corrTake_i;
                ckpt_q  <= sba_checkPoint_i;
                act_q   <= sba_repairAction_i[3:1];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = REDIR;
        end else begin
            case (state)
                IDLE:   state_nxt = IDLE;
                REDIR: begin
                    if (act_q[1])      state_nxt = BTB_WR;
                    else if (act_q[2]) state_nxt = PHT_WR;
                    else               state_nxt = IDLE;
                end
                BTB_WR: begin
                    if (btb_upd_ready_i) state_nxt = act_q[2] ? PHT_WR : IDLE;
                end
                PHT_WR: begin
                    if (pht_upd_ready_i) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A CP0 exception during REDIR owns the fetch redirect; training still goes ahead.
    always_comb begin
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        ckpt_restore_o   = 1'b0;
        ras_restore_o    = 1'b0;
        ckpt_o           = '0;
        btb_upd_valid_o  = 1'b0;
        btb_upd_pc_o     = '0;
        btb_upd_target_o = '0;
        pht_upd_valid_o  = 1'b0;
        pht_upd_pc_o     = '0;
        pht_upd_take_o   = 1'b0;
        busy_o           = (state != IDLE);
        case (state)
            REDIR: begin
                if (!cp0_excOccur_i) begin
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = rpc_q;
                    ckpt_restore_o   = 1'b1;
                    ras_restore_o    = act_q[3];
                    ckpt_o           = ckpt_q;
                end
            end
            BTB_WR: begin
                btb_upd_valid_o  = 1'b1;
                btb_upd_pc_o     = vaddr_q;
                btb_upd_target_o = dest_q;
            end
            PHT_WR: begin
                pht_upd_valid_o = 1'b1;
                pht_upd_pc_o    = vaddr_q;
                pht_upd_take_o  = take_q;
            end
            default: ;
        endcase
    end

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst)        perf_cnt_q <= '0;
        else if (accept) perf_cnt_q <= perf_cnt_q + 32'd1;
    end

    assign perf_repair_cnt_o = perf_cnt_q;
`else
    assign perf_repair_cnt_o = '0;
`endif

endmodule
